// File: rtl/ula_pkg.sv
// Shared opcode constants and FSM state encoding for the ULA controller.
package ula_pkg;

  // Opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASB = 3'b111;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_MUL  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // MUL is the only opcode that goes through the multi-cycle sequencer
  function automatic logic is_mul_op(input logic [2:0] op_code);
    return op_code == OP_MUL;
  endfunction

endpackage

// File: rtl/ula_alu_comb.sv
// Single-cycle combinational ALU. MUL is sequenced by the controller,
// so this block returns zero for that opcode.
module ula_alu_comb
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;

  // Opcode decode; carry is only meaningful for ADD/SUB
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b};
    result  = '0;
    carry   = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a >= b);  // carry set means no borrow
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOTA: result = ~a;
      OP_MUL:  result = '0;
      OP_PASB: result = b;
    endcase
  end

endmodule

// File: rtl/ula_controller.sv
// ULA controller: request/result handshakes around a combinational ALU
// plus a shift-add multiplier that takes WIDTH cycles.
module ula_controller
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q,  state_d;
  logic [2:0]         op_q,     op_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q,  carry_d;
  logic               zero_q,   zero_d;

  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic [2*WIDTH-1:0] step_sum;

  ula_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Next-state logic for the FSM, operand capture and the MUL sequencer
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        // req_ready is high here, so req_valid alone is the handshake
        if (req_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mul_op(op_q)) begin
          acc_d    = '0;
          mplier_d = b_q;
          mcand_d  = {{WIDTH{1'b0}}, a_q};
          cnt_d    = '0;
          state_d  = ST_MUL;
        end else begin
          result_d = alu_result;
          carry_d  = alu_carry;
          zero_d   = (alu_result == '0);
          state_d  = ST_DONE;
        end
      end
      ST_MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last of WIDTH steps: the product is complete in step_sum
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = step_sum[WIDTH-1:0];
          carry_d  = |step_sum[2*WIDTH-1:WIDTH];
          zero_d   = (step_sum[WIDTH-1:0] == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Result and flags are held; leaving via IDLE means the next
        // request can be accepted one cycle after the result handshake.
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: doc/ula_controller.md
ULA_CONTROLLER -- requirements
Module: ula_controller

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MUL, 111 PASS B.
REQ-007 a, b  input  WIDTH each  operands, sampled only on request handshake.
REQ-008 res_valid  output  1  result/flags valid.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  registered result.
REQ-011 carry, zero  output  1 each  registered flags.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, DONE; req_ready = (state==IDLE), res_valid = (state==DONE).
REQ-014 Request handshake (req_valid && req_ready) at edge T SHALL capture op, a, b into internal registers and move to EXEC.
REQ-015 In EXEC, non-MUL ops SHALL register result/flags and move to DONE; res_valid high from T+2.
REQ-016 In EXEC, MUL SHALL initialise accumulator=0, multiplier=b, multiplicand=a, count=0, then move to MUL.
REQ-017 MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles, then register result and move to DONE; res_valid high from T+2+WIDTH.
REQ-018 ADD: result=(a+b) mod 2^WIDTH, carry=bit WIDTH of the sum.
REQ-019 SUB: result=(a-b) mod 2^WIDTH, carry=1 when a>=b (no borrow), else 0.
REQ-020 Logic ops, NOT A, PASS B: carry=0.
REQ-021 MUL: result=low WIDTH bits of a*b, carry=1 when any high WIDTH bit of the 2*WIDTH product is nonzero.
REQ-022 zero SHALL be 1 exactly when the registered result is all zeros.
REQ-023 DONE SHALL hold result, carry, zero stable until res_ready is high; on res_valid && res_ready move to IDLE.
REQ-024 No new request SHALL be accepted in the cycle of the result handshake; earliest next acceptance is the following cycle.
REQ-025 req_valid while not IDLE SHALL be ignored; operand inputs changing outside handshake SHALL NOT affect an operation in progress.
REQ-026 Unused/illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 rst low SHALL immediately force state=IDLE, result=0, carry=0, zero=0, internal operand/accumulator/count registers=0, independent of clk.
REQ-028 During and after reset: req_ready=1, res_valid=0, busy=0.
REQ-029 Reset during EXEC, MUL or DONE SHALL abort the operation with no result delivered.

Structure
REQ-030 Shared package ula_pkg SHALL hold opcode constants and the FSM state encoding.
REQ-031 Combinational single-cycle ALU SHALL be sub-module ula_alu_comb (op, a, b -> result, carry); the controller owns all registers and the MUL sequencer.

Verification (WIDTH=4)
REQ-032 ADD a=4'h9 b=4'h8, res_ready=1 -> result=4'h1, carry=1, zero=0, res_valid exactly 2 cycles after handshake.
REQ-033 SUB a=4'h5 b=4'h5 -> result=4'h0, zero=1, carry=1; SUB a=4'h3 b=4'h5 -> result=4'hE, carry=0.
REQ-034 MUL a=4'h6 b=4'h7 -> result=4'hA, carry=1, res_valid at T+6; MUL a=4'h3 b=4'h5 -> result=4'hF, carry=0.
REQ-035 Backpressure: res_ready low 3 cycles in DONE with req_valid high and a/b toggling -> result/flags stable, req_ready=0, no second capture.
REQ-036 rst low during 2nd MUL cycle -> outputs zero at once, req_ready=1; after release, next ADD 4'h1+4'h1 -> result=4'h2.
